rrp_arbiter_wrr: RTL and testbench

//  Parametrised successor of the round-robin FIFO arbiter merging RX, TLU, TDC (and future) word streams

---
 rtl/rrp_arbiter_wrr_if.sv | 30 +++
 rtl/rrp_arbiter_wrr.sv | 142 ++++++++++++++
 tb/tb_rrp_arbiter_wrr.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rrp_arbiter_wrr_if.sv
// Channel-side and downstream-side signal bundle of the weighted round-robin arbiter.
// slave = the arbiter's view, master = the view of the logic around it.
interface rrp_arbiter_wrr_if #(
    parameter int WIDTH      = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int ID_WIDTH = $clog2(WIDTH);

    logic [WIDTH-1:0]            CH_ENABLE;
    logic [WIDTH-1:0]            WRITE_REQ;
    logic [WIDTH-1:0]            HOLD_REQ;
    logic [WIDTH*DATA_WIDTH-1:0] DATA_IN;
    logic [WIDTH-1:0]            READ_GRANT;
    logic                        READY_OUT;
    logic                        WRITE_OUT;
    logic [DATA_WIDTH-1:0]       DATA_OUT;
    logic                        GRANT_VALID;
    logic [ID_WIDTH-1:0]         GRANT_ID;
    logic                        HOLD_TIMEOUT_ERR;

    modport slave (
        input  CH_ENABLE, WRITE_REQ, HOLD_REQ, DATA_IN, READY_OUT,
        output READ_GRANT, WRITE_OUT, DATA_OUT, GRANT_VALID, GRANT_ID, HOLD_TIMEOUT_ERR
    );

    modport master (
        output CH_ENABLE, WRITE_REQ, HOLD_REQ, DATA_IN, READY_OUT,
        input  READ_GRANT, WRITE_OUT, DATA_OUT, GRANT_VALID, GRANT_ID, HOLD_TIMEOUT_ERR
    );
endinterface

// File: rtl/rrp_arbiter_wrr.sv
// Round-robin arbiter merging WIDTH FWFT word streams into one registered output.
// A grant lasts until the channel is disabled, drains, hits its burst limit
// (unless holding) or holds an empty FIFO for HOLD_TIMEOUT cycles. Every
// release passes through IDLE, giving a one-cycle bubble between grants.
module rrp_arbiter_wrr #(
    parameter int WIDTH        = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int BURST_MAX    = 16,
    parameter int HOLD_TIMEOUT = 255
) (
    input logic              CLK,
    input logic              RST_N,
    rrp_arbiter_wrr_if.slave bus
);
    localparam int IW = $clog2(WIDTH);
    localparam int BW = (BURST_MAX == 0) ? 1 : $clog2(BURST_MAX + 1);
    localparam int TW = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [BW-1:0] BURST_LIM   = BW'(BURST_MAX);
    localparam logic [TW-1:0] TIMEOUT_LIM = TW'(HOLD_TIMEOUT);
    localparam logic          BURST_ON    = (BURST_MAX != 0);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t                state;
    logic [IW-1:0]         cur;
    logic [IW-1:0]         last_ptr;
    logic [BW-1:0]         burst_cnt;
    logic [TW-1:0]         timeout_cnt;
    logic                  write_out_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  timeout_err_q;

    logic [DATA_WIDTH-1:0] ch_data [WIDTH];
    logic [WIDTH-1:0]      cand;
    logic                  pick_valid;
    logic [IW-1:0]         pick;
    logic [IW-1:0]         scan_idx;
    logic                  cur_en, cur_req, cur_hold;
    logic                  rel_en, rel_empty, rel_burst, rel_timeout;
    logic                  release_now;
    logic                  pop;
    logic [WIDTH-1:0]      read_grant;

    for (genvar k = 0; k < WIDTH; k++) begin : g_ch_data
        assign ch_data[k] = bus.DATA_IN[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign cand     = bus.WRITE_REQ & bus.CH_ENABLE;
    assign cur_en   = bus.CH_ENABLE[cur];
    assign cur_req  = bus.WRITE_REQ[cur];
    assign cur_hold = bus.HOLD_REQ[cur];

    // Release conditions of the owning channel; disable wins over hold.
    assign rel_en      = ~cur_en;
    assign rel_empty   = ~cur_hold & ~cur_req;
    assign rel_burst   = ~cur_hold & BURST_ON & (burst_cnt == BURST_LIM);
    assign rel_timeout = cur_en & cur_hold & (timeout_cnt == TIMEOUT_LIM);
    assign release_now = (state == ST_GRANT) & (rel_en | rel_empty | rel_burst | rel_timeout);

    // A pop never happens in the cycle the grant is being released.
    assign pop = (state == ST_GRANT) & cur_req & bus.READY_OUT & cur_en & ~release_now;

    // Round-robin pick: first candidate after the last owner, wrapping around.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        pick_valid = 1'b0;
        pick       = '0;
        scan_idx   = '0;
        for (int i = 1; i <= WIDTH; i++) begin
            scan_idx = IW'((int'(last_ptr) + i) % WIDTH);
            if (!pick_valid && cand[scan_idx]) begin
                pick_valid = 1'b1;
                pick       = scan_idx;
            end
        end
    end

    // Pop strobe back to the owning channel FIFO, one-hot or zero.
    always_comb begin
        read_grant      = '0;
        read_grant[cur] = pop;
    end

    // Arbitration FSM with its counters and the registered output stage.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
        if (!RST_N) begin
            state         <= ST_IDLE;
            cur           <= '0;
            last_ptr      <= IW'(WIDTH - 1);
            burst_cnt     <= '0;
            timeout_cnt   <= '0;
            write_out_q   <= 1'b0;
            data_out_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            write_out_q   <= pop;
            timeout_err_q <= release_now & rel_timeout;
            if (pop) begin
                data_out_q <= ch_data[cur];
            end
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state       <= ST_GRANT;
                        cur         <= pick;
                        burst_cnt   <= '0;
                        timeout_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        state       <= ST_IDLE;
                        last_ptr    <= cur;
                        burst_cnt   <= '0;
                        timeout_cnt <= '0;
                    end else begin
                        if (pop && burst_cnt != BURST_LIM) begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                        if (pop || !cur_hold) begin
                            timeout_cnt <= '0;
                        end else if (!cur_req && timeout_cnt != TIMEOUT_LIM) begin
                            timeout_cnt <= timeout_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.READ_GRANT       = read_grant;
    assign bus.WRITE_OUT        = write_out_q;
    assign bus.DATA_OUT         = data_out_q;
    assign bus.GRANT_VALID      = (state == ST_GRANT);
    assign bus.GRANT_ID         = cur;
    assign bus.HOLD_TIMEOUT_ERR = timeout_err_q;
endmodule

// File: tb/tb_rrp_arbiter_wrr.sv
// Bench for rrp_arbiter_wrr: a cycle table from reset, then FIFO-backed
// scenarios for bursts, hold, timeout, back-pressure, disable and reset.
module tb_rrp_arbiter_wrr;
    localparam int WIDTH      = 4;
    localparam int DATA_WIDTH = 32;
    typedef logic [DATA_WIDTH-1:0] word_t;

    typedef struct {
        logic [WIDTH-1:0] en;
        logic [WIDTH-1:0] wreq;
        logic [WIDTH-1:0] hold;
        logic             rdy;
        logic [WIDTH-1:0] exp_rg;
        logic             exp_gv;
        logic [1:0]       exp_gid;
        logic             exp_wo;
        word_t            exp_dout;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rrp_arbiter_wrr_if #(.WIDTH(WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    rrp_arbiter_wrr #(
        .WIDTH(WIDTH), .DATA_WIDTH(DATA_WIDTH), .BURST_MAX(16), .HOLD_TIMEOUT(255)
    ) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (bus.slave)
    );

    int    n_vec = 0;
    int    n_err = 0;
    word_t fifo_q [WIDTH][$];
    bit    use_fifo = 1'b0;
    int    cyc = 0;
    int    inv_bad = 0;
    int    pop_cyc[$];
    int    pop_ch[$];
    int    wo_cyc[$];
    word_t wo_data[$];
    int    err_cyc[$];
    word_t exp_q[$];
    int    run_ch[$];
    int    run_len[$];
    int    run_start[$];
    int    run_end[$];
    vec_t  vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic word_t mk(input int ch, input int n);
        return 32'hC000_0000 + word_t'(ch) * 32'h0100_0000 + word_t'(n);
    endfunction

    function automatic int fifo_total();
        int s = 0;
        for (int k = 0; k < WIDTH; k++) s += fifo_q[k].size();
        return s;
    endfunction

    task automatic drive_fifo();
        for (int k = 0; k < WIDTH; k++) begin
            bus.WRITE_REQ[k] = (fifo_q[k].size() != 0);
            bus.DATA_IN[k*DATA_WIDTH +: DATA_WIDTH] = (fifo_q[k].size() != 0) ? fifo_q[k][0] : '0;
        end
    endtask

    task automatic clear_logs();
        pop_cyc.delete(); pop_ch.delete(); wo_cyc.delete(); wo_data.delete();
        err_cyc.delete(); exp_q.delete();
        inv_bad = 0;
    endtask

    // One clock: sample at the falling edge, let the FIFO model pop after the rising edge.
    task automatic tick();
        logic [WIDTH-1:0] rg;
        @(negedge clk);
        rg = bus.READ_GRANT;
        if ((rg & ~bus.WRITE_REQ) != 0 || $countones(rg) > 1 || (rg != 0 && !bus.READY_OUT))
            inv_bad++;
        for (int k = 0; k < WIDTH; k++) begin
            if (rg[k]) begin
                pop_cyc.push_back(cyc);
                pop_ch.push_back(k);
            end
        end
        if (bus.WRITE_OUT) begin
            wo_cyc.push_back(cyc);
            wo_data.push_back(bus.DATA_OUT);
        end
        if (bus.HOLD_TIMEOUT_ERR) err_cyc.push_back(cyc);
        @(posedge clk);
        #1;
        cyc++;
        if (use_fifo) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (rg[k] && fifo_q[k].size() != 0) void'(fifo_q[k].pop_front());
            end
            drive_fifo();
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " READ_GRANT"}, bus.READ_GRANT, 0);
        check({tag, " WRITE_OUT"}, bus.WRITE_OUT, 0);
        check({tag, " DATA_OUT"}, bus.DATA_OUT, 0);
        check({tag, " GRANT_VALID"}, bus.GRANT_VALID, 0);
        check({tag, " GRANT_ID"}, bus.GRANT_ID, 0);
        check({tag, " HOLD_TIMEOUT_ERR"}, bus.HOLD_TIMEOUT_ERR, 0);
    endtask

    // Reset with every channel requesting, so a missing reset term would show.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        use_fifo = 1'b0;
        for (int k = 0; k < WIDTH; k++) fifo_q[k].delete();
        bus.CH_ENABLE = '1;
        bus.WRITE_REQ = '1;
        bus.HOLD_REQ  = '0;
        bus.DATA_IN   = '1;
        bus.READY_OUT = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs(tag);
        bus.WRITE_REQ = '0;
        bus.DATA_IN   = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        clear_logs();
    endtask

    task automatic build_runs();
        int n;
        run_ch.delete(); run_len.delete(); run_start.delete(); run_end.delete();
        for (int i = 0; i < pop_cyc.size(); i++) begin
            if (i == 0 || pop_ch[i] != pop_ch[i-1] || pop_cyc[i] != pop_cyc[i-1] + 1) begin
                run_ch.push_back(pop_ch[i]);
                run_len.push_back(1);
                run_start.push_back(pop_cyc[i]);
                run_end.push_back(pop_cyc[i]);
            end else begin
                n = run_len.size() - 1;
                run_len[n] = run_len[n] + 1;
                run_end[n] = pop_cyc[i];
            end
        end
    endtask

    task automatic check_run(input string name, input int idx, input int ch, input int len);
        int a_ch;
        int a_len;
        a_ch = -1;
        a_len = -1;
        if (idx < run_ch.size()) begin
            a_ch  = run_ch[idx];
            a_len = run_len[idx];
        end
        check($sformatf("%s run%0d channel", name, idx), a_ch, ch);
        check($sformatf("%s run%0d length", name, idx), a_len, len);
    endtask

    task automatic check_gap(input string name, input int idx, input int gap);
        int a_gap;
        a_gap = -1;
        if (idx > 0 && idx < run_start.size()) a_gap = run_start[idx] - run_end[idx-1];
        check($sformatf("%s gap before run%0d", name, idx), a_gap, gap);
    endtask

    task automatic check_words(input string name);
        word_t a;
        check({name, " word count"}, wo_data.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            a = (i < wo_data.size()) ? wo_data[i] : '1;
            check($sformatf("%s word%0d", name, i), a, exp_q[i]);
        end
    endtask

    task automatic drain(input string name, input int bound);
        int g;
        g = 0;
        while ((fifo_total() != 0 || bus.GRANT_VALID) && g < bound) begin
            tick();
            g++;
        end
        check({name, " drained within bound"}, g < bound, 1);
        repeat (3) tick();
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;

        // ---------------- table-driven cycle vectors ----------------
        //            en     wreq   hold   rdy   rg     gv    gid   wo    dout
        vecs[0]  = '{4'hF, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 32'h0};
        vecs[1]  = '{4'hF, 4'h6, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 32'h0};
        vecs[2]  = '{4'hF, 4'h6, 4'h0, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0, 32'h0};
        vecs[3]  = '{4'hF, 4'h6, 4'h0, 1'b0, 4'h0, 1'b1, 2'd1, 1'b1, 32'hA000_0001};
        vecs[4]  = '{4'hF, 4'h4, 4'h0, 1'b1, 4'h0, 1'b1, 2'd1, 1'b0, 32'hA000_0001};
        vecs[5]  = '{4'hF, 4'h4, 4'h0, 1'b1, 4'h0, 1'b0, 2'd1, 1'b0, 32'hA000_0001};
        vecs[6]  = '{4'hB, 4'h4, 4'h0, 1'b1, 4'h0, 1'b1, 2'd2, 1'b0, 32'hA000_0001};
        vecs[7]  = '{4'hF, 4'h9, 4'h0, 1'b1, 4'h0, 1'b0, 2'd2, 1'b0, 32'hA000_0001};
        vecs[8]  = '{4'hF, 4'h9, 4'h8, 1'b1, 4'h8, 1'b1, 2'd3, 1'b0, 32'hA000_0001};
        vecs[9]  = '{4'hF, 4'h1, 4'h8, 1'b1, 4'h0, 1'b1, 2'd3, 1'b1, 32'hA000_0003};
        vecs[10] = '{4'hF, 4'h1, 4'h4, 1'b1, 4'h0, 1'b1, 2'd3, 1'b0, 32'hA000_0003};
        vecs[11] = '{4'hF, 4'h1, 4'h0, 1'b1, 4'h0, 1'b0, 2'd3, 1'b0, 32'hA000_0003};
        vecs[12] = '{4'hF, 4'h1, 4'h0, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0, 32'hA000_0003};

        do_reset("reset");
        bus.DATA_IN = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        for (int i = 0; i < 13; i++) begin
            bus.CH_ENABLE = vecs[i].en;
            bus.WRITE_REQ = vecs[i].wreq;
            bus.HOLD_REQ  = vecs[i].hold;
            bus.READY_OUT = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d READ_GRANT", i), bus.READ_GRANT, vecs[i].exp_rg);
            check($sformatf("vec%0d GRANT_VALID", i), bus.GRANT_VALID, vecs[i].exp_gv);
            check($sformatf("vec%0d GRANT_ID", i), bus.GRANT_ID, vecs[i].exp_gid);
            check($sformatf("vec%0d WRITE_OUT", i), bus.WRITE_OUT, vecs[i].exp_wo);
            check($sformatf("vec%0d DATA_OUT", i), bus.DATA_OUT, vecs[i].exp_dout);
            @(posedge clk);
            #1;
        end

        // ---------------- 1: four channels, three words each ----------------
        do_reset("t1 reset");
        use_fifo = 1'b1;
        for (int k = 0; k < WIDTH; k++)
            for (int n = 0; n < 3; n++) begin
                fifo_q[k].push_back(mk(k, n));
                exp_q.push_back(mk(k, n));
            end
        drive_fifo();
        drain("t1", 100);
        build_runs();
        for (int k = 0; k < WIDTH; k++) check_run("t1", k, k, 3);
        for (int k = 1; k < WIDTH; k++) check_gap("t1", k, 3);
        check_words("t1");
        check("t1 invariants", inv_bad, 0);

        // ---------------- 2: burst limit, ch1 40 words / ch2 5 words ----------------
        do_reset("t2 reset");
        use_fifo = 1'b1;
        for (int n = 0; n < 40; n++) fifo_q[1].push_back(mk(1, n));
        for (int n = 0; n < 5; n++) fifo_q[2].push_back(mk(2, n));
        for (int n = 0; n < 16; n++) exp_q.push_back(mk(1, n));
        for (int n = 0; n < 5; n++) exp_q.push_back(mk(2, n));
        for (int n = 16; n < 40; n++) exp_q.push_back(mk(1, n));
        drive_fifo();
        drain("t2", 200);
        build_runs();
        check_run("t2", 0, 1, 16);
        check_run("t2", 1, 2, 5);
        check_run("t2", 2, 1, 16);
        check_run("t2", 3, 1, 8);
        check_gap("t2", 1, 3);
        check_gap("t2", 3, 3);
        check_words("t2");
        check("t2 invariants", inv_bad, 0);

        // ---------------- 3: hold overrides burst limit ----------------
        do_reset("t3 reset");
        use_fifo = 1'b1;
        for (int n = 0; n < 40; n++) fifo_q[1].push_back(mk(1, n));
        for (int n = 0; n < 5; n++) fifo_q[2].push_back(mk(2, n));
        for (int n = 0; n < 40; n++) exp_q.push_back(mk(1, n));
        for (int n = 0; n < 5; n++) exp_q.push_back(mk(2, n));
        bus.HOLD_REQ = 4'b0010;
        drive_fifo();
        g = 0;
        while (fifo_q[1].size() != 0 && g < 200) begin
            tick();
            g++;
        end
        check("t3 ch1 emptied within bound", g < 200, 1);
        repeat (10) tick();
        check("t3 ch2 untouched while held", fifo_q[2].size(), 5);
        check("t3 grant kept GRANT_VALID", bus.GRANT_VALID, 1);
        check("t3 grant kept GRANT_ID", bus.GRANT_ID, 1);
        bus.HOLD_REQ = 4'b0000;
        drain("t3", 100);
        build_runs();
        check_run("t3", 0, 1, 40);
        check_run("t3", 1, 2, 5);
        check_words("t3");
        check("t3 no timeout pulse", err_cyc.size(), 0);
        check("t3 invariants", inv_bad, 0);

        // ---------------- 4: held empty grant times out ----------------
        do_reset("t4 reset");
        use_fifo = 1'b1;
        fifo_q[0].push_back(mk(0, 0));
        fifo_q[3].push_back(mk(3, 0));
        fifo_q[3].push_back(mk(3, 1));
        exp_q.push_back(mk(0, 0));
        exp_q.push_back(mk(3, 0));
        exp_q.push_back(mk(3, 1));
        bus.HOLD_REQ = 4'b0001;
        drive_fifo();
        drain("t4", 400);
        build_runs();
        check_run("t4", 0, 0, 1);
        check_run("t4", 1, 3, 2);
        check("t4 timeout pulse count", err_cyc.size(), 1);
        if (err_cyc.size() == 1 && run_start.size() == 2) begin
            check("t4 pulse after last ch0 pop", err_cyc[0] - pop_cyc[0], 257);
            check("t4 ch3 pop after pulse", run_start[1] - err_cyc[0], 1);
        end
        check_words("t4");
        check("t4 invariants", inv_bad, 0);
        bus.HOLD_REQ = 4'b0000;

        // ---------------- 5: READY_OUT toggling ----------------
        do_reset("t5 reset");
        use_fifo = 1'b1;
        for (int n = 0; n < 6; n++) begin
            fifo_q[2].push_back(mk(2, n));
            exp_q.push_back(mk(2, n));
        end
        drive_fifo();
        g = 0;
        while ((fifo_total() != 0 || bus.GRANT_VALID) && g < 100) begin
            bus.READY_OUT = (g % 2 == 0);
            tick();
            g++;
        end
        check("t5 drained within bound", g < 100, 1);
        bus.READY_OUT = 1'b1;
        repeat (3) tick();
        check("t5 pop count", pop_cyc.size(), 6);
        for (int i = 0; i < pop_cyc.size(); i++) begin
            g = (i < wo_cyc.size()) ? wo_cyc[i] : -1;
            check($sformatf("t5 WRITE_OUT latency word%0d", i), g - pop_cyc[i], 1);
        end
        check_words("t5");
        check("t5 pops only with READY_OUT", inv_bad, 0);

        // ---------------- 6: disable mid-burst with hold, then async reset ----------------
        do_reset("t6 reset");
        use_fifo = 1'b1;
        for (int n = 0; n < 10; n++) fifo_q[2].push_back(mk(2, n));
        bus.HOLD_REQ = 4'b0100;
        drive_fifo();
        g = 0;
        while (pop_ch.size() < 3 && g < 50) begin
            tick();
            g++;
        end
        check("t6 three pops within bound", g < 50, 1);
        bus.CH_ENABLE = 4'b1011;
        repeat (5) tick();
        check("t6 no pops after disable", pop_ch.size(), 3);
        check("t6 ch2 words left", fifo_q[2].size(), 7);
        check("t6 grant dropped", bus.GRANT_VALID, 0);
        bus.CH_ENABLE = 4'b1111;
        g = 0;
        while (pop_ch.size() < 5 && g < 50) begin
            tick();
            g++;
        end
        check("t6 re-enabled pops within bound", g < 50, 1);
        check("t6 word in flight", bus.WRITE_OUT, 1);
        check("t6 owner before reset", bus.GRANT_ID, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("t6 async reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.HOLD_REQ = 4'b0000;
        @(posedge clk);
        #1;
        clear_logs();
        for (int n = 5; n < 10; n++) exp_q.push_back(mk(2, n));
        drain("t6", 100);
        check_words("t6 after reset");
        check("t6 invariants", inv_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
